borrow_chain_sub: RTL and testbench

- Multi-cycle wide subtractor for the carry-lookahead arithmetic group.
- Computes diff = a - b - bin over WIDTH bits, CHUNK bits per clock, LSB chunk first.
- Inside each chunk, a lookahead borrow generator computes the borrow; the borrow between chunks is registered.
- This block is the subtraction counterpart of the lookahead carry generator. It sits between operand producers and result consumers, with a valid/ready handshake on each side.

---
 rtl/borrow_chain_pkg.sv | 18 +
 rtl/borrow_chain_sub_borrow_gen.sv | 39 +++
 rtl/borrow_chain_sub.sv | 138 +++++++++++++
 tb/tb_borrow_chain_sub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/borrow_chain_pkg.sv
// Shared types and defaults for the chunked borrow-chain subtractor.
package borrow_chain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int CHUNK_DEF  = 4;
    localparam int NCHUNK_DEF = 4;

    // Chunk counter width; a single-chunk build still needs a 1-bit counter.
    function automatic int cnt_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/borrow_chain_sub_borrow_gen.sv
// Combinational CHUNK-bit subtract slice with generate/propagate lookahead borrow.
module borrow_gen #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_k,
    input  logic [CHUNK-1:0] b_k,
    input  logic             bin,
    output logic [CHUNK-1:0] d_k,
    output logic             bout
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   brw;

    assign g = ~a_k & b_k;
    assign p = ~(a_k ^ b_k);

    // Each borrow is built as an OR of product terms over g/p/bin only, never from brw[i].
    always_comb begin : lookahead
        logic pp;
        logic br;
        brw    = '0;
        brw[0] = bin;
        for (int i = 0; i < CHUNK; i++) begin
            pp = 1'b1;
            br = 1'b0;
            for (int j = i; j >= 0; j--) begin
                br = br | (pp & g[j]);
                pp = pp & p[j];
            end
            brw[i+1] = br | (pp & bin);
        end
    end

    assign d_k  = a_k ^ b_k ^ brw[CHUNK-1:0];
    assign bout = brw[CHUNK];

endmodule

// File: rtl/borrow_chain_sub.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per clock, LSB chunk first.
// Define BORROW_CHAIN_SUB_FLAGS_EN to add the registered zero/ovf result flags.
module borrow_chain_sub
    import borrow_chain_pkg::*;
#(
    parameter int CHUNK  = CHUNK_DEF,
    parameter int NCHUNK = NCHUNK_DEF,
    parameter int WIDTH  = CHUNK * NCHUNK  // derived, leave at default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_w(NCHUNK);

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
`endif

    int               idx;
    logic [CHUNK-1:0] a_k, b_k, d_k;
    logic             bo_k;

    assign idx = int'(cnt_q) * CHUNK;
    assign a_k = a_q[idx +: CHUNK];
    assign b_k = b_q[idx +: CHUNK];

    borrow_gen #(.CHUNK(CHUNK)) u_borrow_gen (
        .a_k  (a_k),
        .b_k  (b_k),
        .bin  (borrow_q),
        .d_k  (d_k),
        .bout (bo_k)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[idx +: CHUNK] = d_k;
                borrow_d = bo_k;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    bout_d  = bo_k;
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
                    zero_d  = (diff_d == '0);
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_borrow_chain_sub.sv
// Directed and randomized self-checking bench for borrow_chain_sub (WIDTH=16, CHUNK=4).
module tb_borrow_chain_sub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
    logic         zero, ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    borrow_chain_sub #(.CHUNK(4), .NCHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
        .zero      (zero),
        .ovf       (ovf),
`endif
        .diff      (diff),
        .bout      (bout)
    );

    // Present one operation and wait for out_valid; returns edges from accept to out_valid.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic bi, output int lat, output bit ok);
        int guard;
        ok    = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            n_chk++; n_fail++; ok = 1'b0;
            $display("FAIL op_timeout: out_valid=%0b after %0d edges, required 1", out_valid, lat);
        end
    endtask

    task automatic release_op(input int stall);
        out_ready = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_chk++; if (diff !== 16'h0000) begin n_fail++; $display("FAIL reset_diff: got %h want 0000", diff); end
        n_chk++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %0b want 0", bout); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat; bit ok;
        start_op(16'h1234, 16'h0034, 1'b0, lat, ok);
        n_chk++; if (lat != 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_chk++; if (diff !== 16'h1200) begin n_fail++; $display("FAIL basic_diff: got %h want 1200", diff); end
        n_chk++; if (bout !== 1'b0) begin n_fail++; $display("FAIL basic_bout: got %0b want 0", bout); end
        release_op(0);
    endtask

    task automatic test_wrap;
        int lat; bit ok;
        start_op(16'h0000, 16'h0001, 1'b0, lat, ok);
        n_chk++; if (diff !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_diff: got %h want ffff", diff); end
        n_chk++; if (bout !== 1'b1) begin n_fail++; $display("FAIL wrap_bout: got %0b want 1", bout); end
        release_op(0);
        start_op(16'h0000, 16'h0001, 1'b1, lat, ok);
        n_chk++; if (diff !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_bin_diff: got %h want fffe", diff); end
        n_chk++; if (bout !== 1'b1) begin n_fail++; $display("FAIL wrap_bin_bout: got %0b want 1", bout); end
        release_op(0);
        start_op(16'hABCD, 16'hABCD, 1'b0, lat, ok);
        n_chk++; if (diff !== 16'h0000) begin n_fail++; $display("FAIL equal_diff: got %h want 0000", diff); end
        n_chk++; if (bout !== 1'b0) begin n_fail++; $display("FAIL equal_bout: got %0b want 0", bout); end
        release_op(0);
    endtask

    task automatic test_backpressure;
        int lat; bit ok;
        start_op(16'h9000, 16'h1000, 1'b0, lat, ok);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // Stray operands during DONE must not be accepted.
            in_valid = 1'b1; a = 16'h0F00; b = 16'h0001; bin = 1'b1;
            @(posedge clk); #1;
            n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, out_valid); end
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
            n_chk++; if (diff !== 16'h8000) begin n_fail++; $display("FAIL bp_diff[%0d]: got %h want 8000", i, diff); end
            n_chk++; if (bout !== 1'b0) begin n_fail++; $display("FAIL bp_bout[%0d]: got %0b want 0", i, bout); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %0b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %0b want 1", in_ready); end
        n_chk++; if (diff !== 16'h8000) begin n_fail++; $display("FAIL bp_idle_hold: got %h want 8000", diff); end
    endtask

    task automatic test_reset_mid;
        int lat; bit ok;
        a = 16'hFFFF; b = 16'h0F0F; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %0b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %0b want 0", out_valid); end
        n_chk++; if (diff !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_diff: got %h want 0000", diff); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_next_in_ready: got %0b want 1", in_ready); end
        start_op(16'hFFFF, 16'h0F0F, 1'b0, lat, ok);
        n_chk++; if (diff !== 16'hF0F0) begin n_fail++; $display("FAIL mid_rst_redo_diff: got %h want f0f0", diff); end
        n_chk++; if (bout !== 1'b0) begin n_fail++; $display("FAIL mid_rst_redo_bout: got %0b want 0", bout); end
        release_op(0);
    endtask

`ifdef BORROW_CHAIN_SUB_FLAGS_EN
    task automatic test_flags;
        int lat; bit ok;
        start_op(16'h8000, 16'h0001, 1'b0, lat, ok);
        n_chk++; if (diff !== 16'h7FFF) begin n_fail++; $display("FAIL flags_ovf_diff: got %h want 7fff", diff); end
        n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL flags_ovf: got %0b want 1", ovf); end
        n_chk++; if (zero !== 1'b0) begin n_fail++; $display("FAIL flags_ovf_zero: got %0b want 0", zero); end
        release_op(0);
        start_op(16'h5555, 16'h5555, 1'b0, lat, ok);
        n_chk++; if (zero !== 1'b1) begin n_fail++; $display("FAIL flags_zero: got %0b want 1", zero); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL flags_zero_ovf: got %0b want 0", ovf); end
        release_op(0);
    endtask
`endif

    task automatic test_random;
        int lat; bit ok;
        logic [W-1:0] ra, rb;
        logic         rbin;
        logic [W:0]   ref_r;
        for (int n = 0; n < 1000; n++) begin
            ra    = W'($urandom);
            rb    = W'($urandom);
            rbin  = 1'($urandom);
            ref_r = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            start_op(ra, rb, rbin, lat, ok);
            n_chk++;
            if (diff !== ref_r[W-1:0] || bout !== ref_r[W]) begin
                n_fail++;
                $display("FAIL random[%0d] %h-%h-%0b: got diff=%h bout=%0b want diff=%h bout=%0b",
                         n, ra, rb, rbin, diff, bout, ref_r[W-1:0], ref_r[W]);
            end
            release_op(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_reset_mid;
`ifdef BORROW_CHAIN_SUB_FLAGS_EN
        test_flags;
`endif
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
